mcs4_shift_register_n: RTL and testbench

Parametrised, cascadable MCS-4 shift register for the i4003 family. It qualifies the slow CP strobe against a nanosecond latch delay using the system clock, then shifts on the qualified rising edge and updates the cascade output on the qualified falling edge. Over the basic part it adds configurable width, a selectable shift direction, a synchronous parallel load and a shift-count/full indicator. It sits on the MCS-4 I/O side wherever keyboard, display or printer expansion is needed, and chains with other instances through `serial_in`/`serial_out`.

---
 rtl/mcs4_shift_register_n.sv | 96 +++++++++
 tb/tb_mcs4_shift_register_n.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_shift_register_n.sv
// Cascadable i4003-style shift register: CP strobe qualified on sysclk,
// shift on qualified rise, cascade output on qualified fall.
module mcs4_shift_register_n #(
  parameter int SYSCLK_TCY     = 20,
  parameter int WIDTH          = 10,
  parameter int LATCH_DELAY_NS = 250
) (
  input  logic             sysclk,
  input  logic             sysreset,
  input  logic             cp,
  input  logic             serial_in,
  input  logic             shift_dir,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             enable,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic             full
);

  localparam int LATCH_DELAY_CY =
    (LATCH_DELAY_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
  localparam int CW = $clog2(LATCH_DELAY_CY + 1);
  localparam int NW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] DLY_MAX = CW'(LATCH_DELAY_CY);
  localparam logic [NW-1:0] CNT_MAX = NW'(WIDTH);

  logic             cp_q, cp_d;
  logic [CW-1:0]    dly_q, dly_d;
  logic             rise, fall;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             so_q, so_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;

  // Any sample back at the qualified level restarts the delay.
  always_comb begin
    cp_d  = cp_q;
    dly_d = '0;
    rise  = 1'b0;
    fall  = 1'b0;
    if (cp != cp_q) begin
      if (dly_q == DLY_MAX) begin
        cp_d = cp;
        rise = cp;
        fall = ~cp;
      end else begin
        dly_d = dly_q + CW'(1);
      end
    end
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    so_d    = so_q;
    if (load) begin
      shift_d = parallel_in;
      cnt_d   = '0;
    end else if (rise) begin
      if (shift_dir)
        shift_d = {serial_in, shift_q[WIDTH-1:1]};
      else
        shift_d = {shift_q[WIDTH-2:0], serial_in};
      if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + NW'(1);
    end
    if (fall)
      so_d = shift_dir ? shift_q[0] : shift_q[WIDTH-1];
    full_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      cp_q    <= 1'b0;
      dly_q   <= '0;
      shift_q <= '0;
      so_q    <= 1'b0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      cp_q    <= cp_d;
      dly_q   <= dly_d;
      shift_q <= shift_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

  assign parallel_out = enable ? shift_q : '0;
  assign serial_out   = so_q;
  assign full         = full_q;

endmodule

// File: tb/tb_mcs4_shift_register_n.sv
// Directed bench for mcs4_shift_register_n with a per-cycle
// behavioural model and hand-computed literal checks.
module tb_mcs4_shift_register_n;

  localparam int W   = 10;
  localparam int LAT = 13;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         cp   = 1'b0;
  logic         si   = 1'b0;
  logic         dir  = 1'b0;
  logic         load = 1'b0;
  logic         en   = 1'b1;
  logic [W-1:0] pin  = '0;
  logic [W-1:0] pinb = '0;
  logic         zero = 1'b0;
  logic         one  = 1'b1;

  logic [W-1:0] po, pob;
  logic         so, full, sob, fullb;

  int checks = 0;
  int fails  = 0;

  always #10 clk = ~clk;

  mcs4_shift_register_n dut (
    .sysclk(clk), .sysreset(rst), .cp(cp),
    .serial_in(si), .shift_dir(dir), .load(load),
    .parallel_in(pin), .enable(en),
    .parallel_out(po), .serial_out(so), .full(full)
  );

  mcs4_shift_register_n dutb (
    .sysclk(clk), .sysreset(rst), .cp(cp),
    .serial_in(so), .shift_dir(zero), .load(zero),
    .parallel_in(pinb), .enable(one),
    .parallel_out(pob), .serial_out(sob), .full(fullb)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: event after LAT+1 consecutive differing samples.
  int           m_run = 0;
  logic         m_lvl = 1'b0;
  logic [W-1:0] m_sh  = '0;
  logic         m_so  = 1'b0;
  int           m_cnt = 0;

  always @(posedge clk) begin
    int  v;
    bit  ev_r, ev_f;
    ev_r = 0;
    ev_f = 0;
    if (rst) begin
      m_run = 0; m_lvl = 0; m_sh = '0; m_so = 0; m_cnt = 0;
    end else begin
      if (cp != m_lvl) begin
        m_run++;
        if (m_run == LAT + 1) begin
          ev_r  = cp;
          ev_f  = !cp;
          m_lvl = cp;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      v = int'(m_sh);
      if (ev_f)
        m_so = dir ? (v % 2 == 1) : (v / (1 << (W-1)) == 1);
      if (load) begin
        m_sh  = pin;
        m_cnt = 0;
      end else if (ev_r) begin
        if (dir) v = v / 2 + int'(si) * (1 << (W-1));
        else     v = (v * 2 + int'(si)) % (1 << W);
        m_sh = W'(v);
        if (m_cnt < W) m_cnt++;
      end
    end
    #1;
    chk("model_parallel_out", 32'(po), 32'(en ? m_sh : '0));
    chk("model_serial_out", 32'(so), 32'(m_so));
    chk("model_full", 32'(full), 32'(m_cnt == W));
  end

  task automatic ncyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cp_cycle(int hi, int lo, logic b);
    si = b;
    cp = 1'b1;
    ncyc(hi);
    cp = 1'b0;
    ncyc(lo);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ncyc(2);
    rst = 1'b0;
  endtask

  logic [W-1:0] bits;
  logic [19:0]  chain;

  initial begin
    // reset with cp high, rise after full delay on release
    cp = 1'b1;
    ncyc(3);
    chk("reset_po", 32'(po), 0);
    chk("reset_so", 32'(so), 0);
    chk("reset_full", 32'(full), 0);
    si  = 1'b1;
    rst = 1'b0;
    ncyc(LAT);
    chk("release_edge12", 32'(po), 0);
    ncyc(1);
    chk("release_edge13", 32'(po), 32'h001);
    cp = 1'b0;
    ncyc(20);

    // normal shift 1,0,1,1,0,0,1,0,1,1
    do_reset();
    bits = 10'b1011001011;
    for (int i = 0; i < W; i++) begin
      cp_cycle(20, 20, bits[W-1-i]);
      if (i == W - 2) chk("full_after9", 32'(full), 0);
    end
    chk("shift_value", 32'(po), 32'h2CB);
    chk("shift_full", 32'(full), 1);
    en = 1'b0;
    ncyc(1);
    chk("enable_off", 32'(po), 0);
    en = 1'b1;
    ncyc(1);

    // glitch reject: 13 high is too short, 14 is enough
    cp_cycle(13, 20, 1'b1);
    chk("glitch13", 32'(po), 32'h2CB);
    si = 1'b0;
    cp = 1'b1;
    ncyc(13);
    chk("glitch14_pre", 32'(po), 32'h2CB);
    ncyc(1);
    chk("glitch14_shift", 32'(po), 32'h196);
    cp = 1'b0;
    ncyc(20);

    // direction and cascade
    dir  = 1'b1;
    pin  = 10'h201;
    load = 1'b1;
    ncyc(1);
    load = 1'b0;
    cp_cycle(20, 20, 1'b0);
    chk("dir1_value", 32'(po), 32'h100);
    chk("dir1_so", 32'(so), 0);
    dir = 1'b0;
    cp  = 1'b1;
    ncyc(16);
    pin  = 10'h201;
    load = 1'b1;
    ncyc(1);
    load = 1'b0;
    ncyc(3);
    cp = 1'b0;
    ncyc(20);
    chk("dir0_value", 32'(po), 32'h201);
    chk("dir0_so", 32'(so), 1);

    // load on the exact rise cycle
    do_reset();
    si = 1'b0;
    cp = 1'b1;
    ncyc(LAT);
    pin  = 10'h3FF;
    load = 1'b1;
    ncyc(1);
    load = 1'b0;
    chk("collide_value", 32'(po), 32'h3FF);
    chk("collide_full", 32'(full), 0);
    ncyc(6);
    cp = 1'b0;
    ncyc(20);
    chk("collide_fall_so", 32'(so), 1);
    for (int i = 0; i < W; i++) begin
      cp_cycle(20, 20, 1'b1);
      if (i == W - 2) chk("collide_cnt9", 32'(full), 0);
    end
    chk("collide_cnt10", 32'(full), 1);

    // load coincident with fall: serial_out takes pre-load bit
    pin  = '0;
    load = 1'b1;
    ncyc(1);
    load = 1'b0;
    cp_cycle(20, 20, 1'b0);
    chk("fall_pre_so", 32'(so), 0);
    cp = 1'b1;
    ncyc(16);
    pin  = 10'h200;
    load = 1'b1;
    ncyc(1);
    load = 1'b0;
    ncyc(3);
    cp = 1'b0;
    ncyc(LAT);
    pin  = 10'h0AA;
    load = 1'b1;
    ncyc(1);
    load = 1'b0;
    chk("fall_load_so", 32'(so), 1);
    chk("fall_load_value", 32'(po), 32'h0AA);
    ncyc(10);

    // two-instance chain
    do_reset();
    chain = {10'b1101001110, 10'b0};
    for (int i = 0; i < 20; i++)
      cp_cycle(20, 20, chain[19-i]);
    chk("chain_b_value", 32'(pob), 32'h34E);
    chk("chain_b_so", 32'(sob), 1);
    chk("chain_b_full", 32'(fullb), 1);
    chk("chain_a_value", 32'(po), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
